// File: rtl/operand_fetch.sv
// Operand fetch stage: captures a decoded instruction, reads the register file,
// resolves writeback bypass and scoreboard hazards, then presents operands to execute.
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_wen,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_ctrl,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_rs1_d,
  input  logic [31:0] rf_rs2_d,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_ctrl,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_wen
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  typedef enum logic [1:0] {IDLE, RD, CHK, ISSUE} state_e;

  typedef struct packed {
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic            rd_wen;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ctrl;
  } instr_t;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ctrl;
    logic [RW-1:0]   rd;
    logic            rd_wen;
  } ex_t;

  state_e          state_q, state_d;
  instr_t          ins_q, ins_d;
  ex_t             ex_q, ex_d;
  logic            ex_valid_q, ex_valid_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            byp1_q, byp1_d, byp2_q, byp2_d;
  logic [XLEN-1:0] byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;

  logic            wb_hit;
  logic            wb_rs1, wb_rs2, wb_rdm;
  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] op1, op2;

  // Writeback to x0 is invisible to both the scoreboard and the bypass path.
  always_comb begin
    wb_hit = wb_valid && (wb_rd != RW'(0));
    wb_rs1 = wb_hit && (wb_rd == ins_q.rs1);
    wb_rs2 = wb_hit && (wb_rd == ins_q.rs2);
    wb_rdm = wb_hit && (wb_rd == ins_q.rd);
  end

  // Operand select: x0, then data latched during RD, then live writeback, then regfile.
  always_comb begin
    if (ins_q.rs1 == RW'(0))  op1 = '0;
    else if (byp1_q)          op1 = byp1_data_q;
    else if (wb_rs1)          op1 = wb_data;
    else                      op1 = rf_rs1_d;

    if (ins_q.rs2 == RW'(0))  op2 = '0;
    else if (byp2_q)          op2 = byp2_data_q;
    else if (wb_rs2)          op2 = wb_data;
    else                      op2 = rf_rs2_d;

    hazard = (busy_q[ins_q.rs1] && !wb_rs1) ||
             (busy_q[ins_q.rs2] && !wb_rs2) ||
             (ins_q.rd_wen && busy_q[ins_q.rd] && !wb_rdm);
  end

  always_comb begin
    state_d     = state_q;
    ins_d       = ins_q;
    ex_d        = ex_q;
    ex_valid_d  = ex_valid_q;
    busy_d      = busy_q;
    byp1_d      = byp1_q;
    byp2_d      = byp2_q;
    byp1_data_d = byp1_data_q;
    byp2_data_d = byp2_data_q;
    id_ready    = 1'b0;
    capture     = 1'b0;

    if (wb_hit) busy_d[wb_rd] = 1'b0;

    case (state_q)
      IDLE: begin
        id_ready = 1'b1;
        if (id_valid) begin
          capture = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        byp1_d = wb_rs1;
        byp2_d = wb_rs2;
        if (wb_rs1) byp1_data_d = wb_data;
        if (wb_rs2) byp2_data_d = wb_data;
        state_d = CHK;
      end
      CHK: begin
        if (hazard) begin
          state_d = RD;
        end else begin
          ex_d.op1    = op1;
          ex_d.op2    = op2;
          ex_d.imm    = ins_q.imm;
          ex_d.pc     = ins_q.pc;
          ex_d.ctrl   = ins_q.ctrl;
          ex_d.rd     = ins_q.rd;
          ex_d.rd_wen = ins_q.rd_wen;
          ex_valid_d  = 1'b1;
          // Set after the writeback clear so a same-cycle set/clear leaves it set.
          if (ins_q.rd_wen && (ins_q.rd != RW'(0))) busy_d[ins_q.rd] = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        id_ready = ex_ready;
        if (ex_ready) begin
          ex_valid_d = 1'b0;
          if (id_valid) begin
            capture = 1'b1;
            state_d = RD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      ins_d.rs1    = id_rs1;
      ins_d.rs2    = id_rs2;
      ins_d.rd     = id_rd;
      ins_d.rd_wen = id_rd_wen;
      ins_d.imm    = id_imm;
      ins_d.pc     = id_pc;
      ins_d.ctrl   = id_ctrl;
      byp1_d       = 1'b0;
      byp2_d       = 1'b0;
    end

    busy_d[0] = 1'b0;
    if (rst) id_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ins_q       <= '0;
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      busy_q      <= '0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ins_q       <= ins_d;
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      busy_q      <= busy_d;
      byp1_q      <= byp1_d;
      byp2_q      <= byp2_d;
      byp1_data_q <= byp1_data_d;
      byp2_data_q <= byp2_data_d;
    end
  end

  assign rf_rs1    = ins_q.rs1;
  assign rf_rs2    = ins_q.rs2;
  assign ex_valid  = ex_valid_q;
  assign ex_op1    = ex_q.op1;
  assign ex_op2    = ex_q.op2;
  assign ex_imm    = ex_q.imm;
  assign ex_pc     = ex_q.pc;
  assign ex_ctrl   = ex_q.ctrl;
  assign ex_rd     = ex_q.rd;
  assign ex_rd_wen = ex_q.rd_wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios, then random traffic checked against
// an architectural register/pending-write model with a registered-read register file.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready, id_rd_wen;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm, id_pc, id_ctrl;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rs1_d, rf_rs2_d;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready, ex_rd_wen;
  logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc, ex_ctrl;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_d(rf_rs1_d), .rf_rs2_d(rf_rs2_d),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen)
  );

  // Register file environment: registered read returning the pre-write value.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    rf_rs1_d <= (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];
    rf_rs2_d <= (rf_rs2 == 5'd0) ? 32'd0 : rf_mem[rf_rs2];
    if (wb_valid && wb_rd != 5'd0) rf_mem[wb_rd] <= wb_data;
  end

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        wen;
    logic [31:0] imm, pc, ctrl;
  } ins_t;

  localparam int NRAND = 300;
  localparam int MAXC  = 20000;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] arch [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    wb_valid = 1'b1; wb_rd = r; wb_data = v;
    tick();
    wb_valid = 1'b0;
    if (r != 5'd0) arch[r] = v;
  endtask

  task automatic send(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic wen, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [31:0] ctrl);
    int k;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_wen = wen;
    id_imm = imm; id_pc = pc; id_ctrl = ctrl; id_valid = 1'b1;
    #1;
    k = 0;
    while (id_ready !== 1'b1 && k < 20) begin
      tick(); #1; k++;
    end
    chk({tag, "_accept"}, 32'(id_ready), 32'd1);
    tick();
    id_valid = 1'b0;
  endtask

  task automatic wait_ex(input string tag, input int exp_n);
    int n;
    n = 0;
    while (ex_valid !== 1'b1 && n < 40) begin
      tick(); n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    ins_t        in_q[$];
    ins_t        cur, e;
    int          due[32];
    logic [31:0] pending;
    logic [31:0] s_op1, s_op2, s_ctrl;
    logic [5:0]  s_rdw;
    logic        have_id, p_id_hs, p_ex_hs, p_ex_valid, p_wb;
    logic [4:0]  p_wb_rd;
    logic [31:0] p_wb_data;
    int          sent, done, cyc, idle;

    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd_wen = 1'b0;
    id_imm = '0; id_pc = '0; id_ctrl = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    ex_ready = 1'b1;
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;

    // Reset state
    tick(); tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd0);
    chk("rst_ex_op1", ex_op1, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_rf_rs1", 32'(rf_rs1), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_exit_id_ready", 32'(id_ready), 32'd1);

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    wb_write(5'd4, 32'd0);
    wb_write(5'd6, 32'h66);

    // Basic fetch with three-cycle latency
    send("basic", 5'd1, 5'd2, 5'd0, 1'b0, 32'h10, 32'h1000, 32'hA);
    wait_ex("basic", 2);
    chk("basic_op1", ex_op1, 32'd5);
    chk("basic_op2", ex_op2, 32'd7);
    chk("basic_imm", ex_imm, 32'h10);
    tick();
    chk("basic_drop", 32'(ex_valid), 32'd0);

    // RAW stall on scoreboard until writeback arrives
    send("raw_prod", 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 32'h1004, 32'h0);
    wait_ex("raw_prod", 2);
    tick();
    send("raw_cons", 5'd3, 5'd0, 5'd5, 1'b1, 32'h0, 32'h1008, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("raw_stall", 32'(ex_valid), 32'd0);
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hAB; arch[3] = 32'hAB;
    tick();
    wb_valid = 1'b0;
    wait_ex("raw_cons", 0);
    chk("raw_op1", ex_op1, 32'hAB);
    tick();
    wb_write(5'd5, 32'd0);

    // Writeback during RD must bypass the stale regfile read
    send("byp", 5'd1, 5'd4, 5'd0, 1'b0, 32'h0, 32'h100C, 32'h0);
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h55; arch[4] = 32'h55;
    tick();
    wb_valid = 1'b0;
    wait_ex("byp", 1);
    chk("byp_op2", ex_op2, 32'h55);
    chk("byp_op1", ex_op1, 32'd5);
    tick();

    // x0 reads zero even when the wb port targets it
    send("x0", 5'd0, 5'd1, 5'd0, 1'b0, 32'h0, 32'h1010, 32'h0);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
    tick();
    wb_valid = 1'b0;
    wait_ex("x0", 1);
    chk("x0_op1", ex_op1, 32'd0);
    chk("x0_op2", ex_op2, 32'd5);
    tick();

    // Backpressure holds the payload; release with a waiting instruction
    ex_ready = 1'b0;
    send("bp", 5'd2, 5'd1, 5'd7, 1'b1, 32'h77, 32'h100, 32'hC0DE);
    wait_ex("bp", 2);
    id_rs1 = 5'd4; id_rs2 = 5'd0; id_rd = 5'd0; id_rd_wen = 1'b0;
    id_imm = 32'h88; id_pc = 32'h104; id_ctrl = 32'h1; id_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_id_ready", 32'(id_ready), 32'd0);
      chk("bp_valid", 32'(ex_valid), 32'd1);
      chk("bp_op1", ex_op1, 32'd7);
      chk("bp_ctrl", ex_ctrl, 32'hC0DE);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_id_ready", 32'(id_ready), 32'd1);
    tick();
    id_valid = 1'b0;
    chk("bp_drop", 32'(ex_valid), 32'd0);
    wait_ex("bp_next", 2);
    chk("bp_next_op1", ex_op1, 32'h55);
    chk("bp_next_imm", ex_imm, 32'h88);
    tick();
    wb_write(5'd7, 32'h7777);

    // Reset in CHK aborts the instruction and clears the scoreboard
    send("rstchk_prod", 5'd1, 5'd2, 5'd6, 1'b1, 32'h0, 32'h200, 32'h0);
    wait_ex("rstchk_prod", 2);
    tick();
    send("rstchk_cons", 5'd6, 5'd0, 5'd0, 1'b0, 32'h0, 32'h204, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstchk_ex_valid", 32'(ex_valid), 32'd0);
    #1;
    chk("rstchk_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("rstchk_no_issue", 32'(ex_valid), 32'd0);
    send("rstchk_after", 5'd6, 5'd1, 5'd0, 1'b0, 32'h0, 32'h208, 32'h0);
    wait_ex("rstchk_after", 2);
    chk("rstchk_after_op1", ex_op1, 32'h66);
    tick();

    // Random traffic against the architectural model
    for (int i = 1; i < 8; i++) wb_write(5'(i), $urandom);
    pending = '0;
    for (int i = 0; i < 32; i++) due[i] = -1;
    have_id = 1'b0; p_id_hs = 1'b0; p_ex_hs = 1'b0; p_ex_valid = 1'b0; p_wb = 1'b0;
    p_wb_rd = '0; p_wb_data = '0;
    s_op1 = '0; s_op2 = '0; s_ctrl = '0; s_rdw = '0;
    sent = 0; done = 0; cyc = 0; idle = 0;
    cur = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, wen: 1'b0, imm: 32'd0, pc: 32'd0, ctrl: 32'd0};

    while (done < NRAND && cyc < MAXC && idle < 200) begin
      if (p_wb && p_wb_rd != 5'd0) begin
        arch[p_wb_rd]    = p_wb_data;
        pending[p_wb_rd] = 1'b0;
      end
      if (p_id_hs) begin
        in_q.push_back(cur);
        have_id = 1'b0;
      end
      if (p_ex_hs) begin
        chk("rand_drop", 32'(ex_valid), 32'd0);
      end else if (p_ex_valid) begin
        chk("rand_hold_op1", ex_op1, s_op1);
        chk("rand_hold_op2", ex_op2, s_op2);
        chk("rand_hold_ctrl", ex_ctrl, s_ctrl);
        chk("rand_hold_rd", 32'({ex_rd, ex_rd_wen}), 32'(s_rdw));
      end
      if (ex_valid && (!p_ex_valid || p_ex_hs)) begin
        idle = 0;
        if (in_q.size() == 0) begin
          chk("rand_spurious", 32'(ex_valid), 32'd0);
        end else begin
          e = in_q.pop_front();
          chk("rand_op1", ex_op1, (e.rs1 == 5'd0) ? 32'd0 : arch[e.rs1]);
          chk("rand_op2", ex_op2, (e.rs2 == 5'd0) ? 32'd0 : arch[e.rs2]);
          chk("rand_imm", ex_imm, e.imm);
          chk("rand_pc", ex_pc, e.pc);
          chk("rand_ctrl", ex_ctrl, e.ctrl);
          chk("rand_rd", 32'({ex_rd, ex_rd_wen}), 32'({e.rd, e.wen}));
          chk("rand_raw1", 32'(pending[e.rs1]), 32'd0);
          chk("rand_raw2", 32'(pending[e.rs2]), 32'd0);
          if (e.wen) chk("rand_waw", 32'(pending[e.rd]), 32'd0);
          if (e.wen && e.rd != 5'd0) begin
            pending[e.rd] = 1'b1;
            due[e.rd]     = cyc + int'($urandom_range(1, 8));
          end
          done++;
        end
        s_op1 = ex_op1; s_op2 = ex_op2; s_ctrl = ex_ctrl; s_rdw = {ex_rd, ex_rd_wen};
      end else begin
        idle++;
      end

      if (!have_id && sent < NRAND && $urandom_range(0, 2) != 0) begin
        cur.rs1  = 5'($urandom_range(0, 7));
        cur.rs2  = 5'($urandom_range(0, 7));
        cur.rd   = 5'($urandom_range(0, 7));
        cur.wen  = 1'($urandom_range(0, 1));
        cur.imm  = $urandom;
        cur.pc   = $urandom;
        cur.ctrl = $urandom;
        have_id  = 1'b1;
        sent++;
      end
      id_valid = have_id;
      id_rs1 = cur.rs1; id_rs2 = cur.rs2; id_rd = cur.rd; id_rd_wen = cur.wen;
      id_imm = cur.imm; id_pc = cur.pc; id_ctrl = cur.ctrl;
      ex_ready = ($urandom_range(0, 3) != 0);

      // At most one writeback every other cycle; owed writebacks go first.
      wb_valid = 1'b0;
      if (!p_wb) begin
        int r;
        r = -1;
        for (int k = 1; k < 8; k++)
          if (r < 0 && due[k] >= 0 && due[k] <= cyc) r = k;
        if (r >= 0) begin
          wb_valid = 1'b1; wb_rd = 5'(r); wb_data = $urandom; due[r] = -1;
        end else if ($urandom_range(0, 5) == 0) begin
          r = int'($urandom_range(0, 7));
          if (!pending[r]) begin
            wb_valid = 1'b1; wb_rd = 5'(r); wb_data = $urandom;
          end
        end
      end
      #1;
      p_id_hs    = id_valid && id_ready;
      p_ex_hs    = ex_valid && ex_ready;
      p_ex_valid = ex_valid;
      p_wb       = wb_valid;
      p_wb_rd    = wb_rd;
      p_wb_data  = wb_data;
      tick();
      cyc++;
    end
    chk("rand_done", 32'(done), 32'(NRAND));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have id_valid (in, 1), id_ready (out, 1), id_rs1 (in, 5), id_rs2 (in, 5), id_rd (in, 5), id_rd_wen (in, 1), id_imm (in, 32), id_pc (in, 32), id_ctrl (in, 32, opaque): the decode-side handshake and instruction fields.
REQ-004 SHALL have rf_rs1 (out, 5), rf_rs2 (out, 5): read addresses to the register file; rf_rs1_d (in, 32), rf_rs2_d (in, 32): its registered read data, valid one cycle after the address is presented.
REQ-005 SHALL have wb_valid (in, 1), wb_rd (in, 5), wb_data (in, 32): the writeback port, identical to the register file's write strobe, address and data.
REQ-006 SHALL have ex_valid (out, 1), ex_ready (in, 1), ex_op1 (out, 32), ex_op2 (out, 32), ex_imm (out, 32), ex_pc (out, 32), ex_ctrl (out, 32), ex_rd (out, 5), ex_rd_wen (out, 1): the execute-side handshake and payload.

Function
REQ-007 SHALL implement FSM states IDLE, RD, CHK, ISSUE.
REQ-008 IDLE: id_ready=1; on id_valid, capture all id_* fields and go to RD.
REQ-009 rf_rs1/rf_rs2 SHALL always equal the captured rs1/rs2; the register file samples them at the end of RD.
REQ-010 RD: for each source, if wb_valid & wb_rd==rs & rs!=0, latch wb_data plus a bypass flag; flags clear on entering RD. Next state CHK.
REQ-011 CHK: operand = 0 if rs==0; else latched bypass data if flag set; else wb_data if wb_valid & wb_rd==rs; else rf_rsN_d (priority in this order).
REQ-012 A 32-bit scoreboard busy[] SHALL mark registers with an issued, not yet written-back write; busy[0] is always 0.
REQ-013 CHK hazard: busy[rs1], busy[rs2], or (id_rd_wen & busy[rd]) SHALL count as a hazard unless wb_valid & wb_rd equals that register in the same cycle.
REQ-014 On a hazard in CHK, the FSM SHALL return to RD (re-read); ex_valid stays 0.
REQ-015 With no hazard in CHK: load ex_* registers, set busy[rd] if rd_wen & rd!=0, go to ISSUE.
REQ-016 busy[wb_rd] SHALL clear on wb_valid; a simultaneous set and clear of the same index SHALL leave it set.
REQ-017 ISSUE: ex_valid=1; all ex_* outputs SHALL hold stable while ex_valid & !ex_ready.
REQ-018 ISSUE: id_ready=ex_ready. On ex_ready with id_valid, capture the new instruction and go to RD; on ex_ready without id_valid, go to IDLE; ex_valid drops the cycle after the handshake.
REQ-019 Minimum latency: id handshake at cycle N gives ex_valid=1 at N+3; best-case throughput is one instruction per 3 cycles.
REQ-020 Writes to x0 on the wb port SHALL be ignored by the scoreboard and bypass.

Reset
REQ-021 While rst=1: state=IDLE, busy=0, ex_valid=0, id_ready=0, all ex_* payload outputs 0, bypass flags 0, captured fields 0.
REQ-022 Reset asserted in any state SHALL abort the in-flight instruction with no ex handshake; id_ready=1 in the first cycle after rst deasserts.

Verification
REQ-023 Reset, then id: rs1=1, rs2=2, imm=0x10, x1=5, x2=7, ex_ready=1 -> ex_valid 3 cycles later, ex_op1=5, ex_op2=7, ex_imm=0x10.
REQ-024 Issue rd=3 (busy), then next instr rs1=3; wb x3=0xAB arrives 4 cycles later -> stall with ex_valid=0 until wb, then ex_op1=0xAB.
REQ-025 wb x4=0x55 in the RD cycle of an instr reading rs2=4 (regfile returns old 0) -> ex_op2=0x55.
REQ-026 rs1=0 with x0 write attempt wb_rd=0 data=0xFF -> ex_op1=0, busy unchanged.
REQ-027 ex_ready=0 for 5 cycles in ISSUE -> ex_* stable, id_ready=0; then ex_ready=1 with id_valid -> new instr accepted same cycle.
REQ-028 rst pulsed during CHK -> no ex_valid, busy all 0, id_ready=1 the following cycle.
